// File: rtl/csr_exec_unit.sv
// Zicsr read-modify-write unit: latches a CSR request, then performs read/modify/write against CSR_RegFile in one EXEC cycle.
// Optional read-only cycle/instret counters are built when CSR_COUNTERS_EN is defined.
module csr_exec_unit #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_rs1_data,
  input  logic [4:0]        req_rs1_idx,
  input  logic              instret_inc,
  output logic              csr_we,
  output logic [AWIDTH-1:0] csr_addr,
  output logic [DWIDTH-1:0] csr_din,
  input  logic [DWIDTH-1:0] csr_dout,
  output logic              wb_valid,
  output logic [DWIDTH-1:0] wb_data,
  output logic              illegal
);

  typedef enum logic {IDLE, EXEC} state_e;

  state_e            state_q;
  logic [1:0]        op_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] operand_q;
  logic [4:0]        rs1_idx_q;

  logic              exec, suppress, bad_op, ro_space, illegal_acc, ctr_hit;
  logic [DWIDTH-1:0] old_val, new_val;

  assign req_ready = (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      operand_q <= '0;
      rs1_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          state_q   <= EXEC;
          op_q      <= req_funct3[1:0];
          addr_q    <= req_addr;
          operand_q <= req_funct3[2] ? {{(DWIDTH-5){1'b0}}, req_rs1_idx} : req_rs1_data;
          rs1_idx_q <= req_rs1_idx;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] cycle_q, instret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_q + 64'd1;
      instret_q <= instret_q + {63'd0, instret_inc};
    end
  end

  // Counters are sampled from their registers, i.e. the value before the commit edge.
  always_comb begin
    ctr_hit = 1'b1;
    old_val = csr_dout;
    case (addr_q)
      AWIDTH'('hC00): old_val = DWIDTH'(cycle_q[31:0]);
      AWIDTH'('hC80): old_val = DWIDTH'(cycle_q[63:32]);
      AWIDTH'('hC02): old_val = DWIDTH'(instret_q[31:0]);
      AWIDTH'('hC82): old_val = DWIDTH'(instret_q[63:32]);
      default:        ctr_hit = 1'b0;
    endcase
  end
`else
  logic unused_instret;
  assign unused_instret = instret_inc;
  assign ctr_hit        = 1'b0;
  assign old_val        = csr_dout;
`endif

  // A synchronous reset landing on the EXEC cycle must cancel the commit, so gate on rst.
  assign exec        = (state_q == EXEC) && !rst;
  assign suppress    = op_q[1] && (rs1_idx_q == 5'd0);
  assign bad_op      = (op_q == 2'b00);
  assign ro_space    = (addr_q[AWIDTH-1 -: 2] == 2'b11);
  assign illegal_acc = bad_op || (ro_space && !suppress);

  always_comb begin
    case (op_q)
      2'b10:   new_val = old_val | operand_q;
      2'b11:   new_val = old_val & ~operand_q;
      default: new_val = operand_q;
    endcase
  end

  assign csr_addr = addr_q;
  assign csr_we   = exec && !illegal_acc && !suppress && !ctr_hit;
  assign csr_din  = exec ? new_val : '0;
  assign wb_valid = exec && !illegal_acc;
  assign wb_data  = wb_valid ? old_val : '0;
  assign illegal  = exec && illegal_acc;

endmodule
